// File: rtl/dcache_pkg.sv
// Shared widths, address-field helpers and FSM encoding for the direct-mapped data cache.
package dcache_pkg;

   localparam int TAG_W  = 23;
   localparam int IDX_W  = 4;
   localparam int OFF_W  = 3;
   localparam int WORD_W = 32;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_WRITEBACK = 2'd1;
   localparam logic [1:0] S_ALLOCATE  = 2'd2;

   typedef enum logic [1:0] {
      IDLE      = S_IDLE,
      WRITEBACK = S_WRITEBACK,
      ALLOCATE  = S_ALLOCATE
   } dcache_state_t;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
      return a[31 -: TAG_W];
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
      return a[OFF_W+2 +: IDX_W];
   endfunction

   function automatic logic [OFF_W-1:0] addr_off(input logic [31:0] a);
      return a[2 +: OFF_W];
   endfunction

   function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                             input logic [IDX_W-1:0] idx);
      return {tag, idx, 5'b0};
   endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side bus of the data cache; master is the controller's view.
interface dcache_if
   import dcache_pkg::*;
#(
   parameter int LINE_BITS = 256
);
   logic                 cpu_req_i;
   logic                 cpu_we_i;
   logic [WORD_W-1:0]    cpu_addr_i;
   logic [WORD_W-1:0]    cpu_data_i;
   logic [WORD_W-1:0]    cpu_data_o;
   logic                 cpu_stall_o;
   logic                 mem_req_o;
   logic                 mem_we_o;
   logic [WORD_W-1:0]    mem_addr_o;
   logic [LINE_BITS-1:0] mem_data_o;
   logic [LINE_BITS-1:0] mem_data_i;
   logic                 mem_ack_i;

   modport master (
      input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
      output cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
   );

   modport slave (
      output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
      input  cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
   );

endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: combinational read, one synchronous write (line fill or word merge).
module dcache_sram
   import dcache_pkg::*;
#(
   parameter int LINES     = 16,
   parameter int LINE_BITS = 256
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [IDX_W-1:0]     idx_i,
   output logic                 valid_o,
   output logic                 dirty_o,
   output logic [TAG_W-1:0]     tag_o,
   output logic [LINE_BITS-1:0] line_o,
   input  logic                 fill_i,
   input  logic [TAG_W-1:0]     fill_tag_i,
   input  logic [LINE_BITS-1:0] fill_line_i,
   input  logic                 store_i,
   input  logic [OFF_W-1:0]     store_off_i,
   input  logic [WORD_W-1:0]    store_word_i
);

   logic [LINES-1:0]     valid_q;
   logic [LINES-1:0]     dirty_q;
   logic [TAG_W-1:0]     tag_q  [LINES];
   logic [LINE_BITS-1:0] data_q [LINES];

   assign valid_o = valid_q[idx_i];
   assign dirty_o = dirty_q[idx_i];
   assign tag_o   = tag_q[idx_i];
   assign line_o  = data_q[idx_i];

   // Only the status bits are cleared; stale tags/data are harmless once valid is low.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_i) begin
         valid_q[idx_i] <= 1'b1;
         dirty_q[idx_i] <= 1'b0;
      end else if (store_i) begin
         dirty_q[idx_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (fill_i) begin
         tag_q[idx_i]  <= fill_tag_i;
         data_q[idx_i] <= fill_line_i;
      end else if (store_i) begin
         data_q[idx_i][{store_off_i, 5'b0} +: WORD_W] <= store_word_i;
      end
   end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache: hit logic, miss FSM and line-memory handshake.
module dcache_controller
   import dcache_pkg::*;
#(
   parameter int LINES     = 16,
   parameter int LINE_BITS = 256
) (
   input  logic     clk_i,
   input  logic     rst_i,
   dcache_if.master bus
);

   dcache_state_t        state_q, state_d;
   logic [TAG_W-1:0]     req_tag;
   logic [IDX_W-1:0]     req_idx;
   logic [OFF_W-1:0]     req_off;
   logic                 line_valid, line_dirty;
   logic [TAG_W-1:0]     line_tag;
   logic [LINE_BITS-1:0] line_data;
   logic                 hit, fill, store;
   logic                 mem_req, mem_we;
   logic [31:0]          mem_addr;
   logic [LINE_BITS-1:0] mem_data;

   assign req_tag = addr_tag(bus.cpu_addr_i);
   assign req_idx = addr_idx(bus.cpu_addr_i);
   assign req_off = addr_off(bus.cpu_addr_i);

   dcache_sram #(
      .LINES     (LINES),
      .LINE_BITS (LINE_BITS)
   ) u_sram (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .idx_i        (req_idx),
      .valid_o      (line_valid),
      .dirty_o      (line_dirty),
      .tag_o        (line_tag),
      .line_o       (line_data),
      .fill_i       (fill),
      .fill_tag_i   (req_tag),
      .fill_line_i  (bus.mem_data_i),
      .store_i      (store),
      .store_off_i  (req_off),
      .store_word_i (bus.cpu_data_i)
   );

   assign hit   = bus.cpu_req_i & line_valid & (line_tag == req_tag);
   assign fill  = (state_q == ALLOCATE) & bus.mem_ack_i;
   assign store = (state_q == IDLE) & hit & bus.cpu_we_i;

   assign bus.cpu_data_o  = hit ? line_data[{req_off, 5'b0} +: WORD_W] : '0;
   assign bus.cpu_stall_o = ((state_q == IDLE) & bus.cpu_req_i & ~hit) | (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (bus.cpu_req_i & ~hit)
                       state_d = (line_valid & line_dirty) ? WRITEBACK : ALLOCATE;
         WRITEBACK: if (bus.mem_ack_i) state_d = ALLOCATE;
         ALLOCATE:  if (bus.mem_ack_i) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Memory outputs decode straight from state so an async reset drops the request at once.
   always_comb begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_data = '0;
      case (state_q)
         WRITEBACK: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = line_addr(line_tag, req_idx);
            mem_data = line_data;
         end
         ALLOCATE: begin
            mem_req  = 1'b1;
            mem_addr = line_addr(req_tag, req_idx);
         end
         default: ;
      endcase
   end

   assign bus.mem_req_o  = mem_req;
   assign bus.mem_we_o   = mem_we;
   assign bus.mem_addr_o = mem_addr;
   assign bus.mem_data_o = mem_data;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench: a flat word-level golden memory plus per-set residency model predict data and traffic.
module tb_dcache_controller;
   import dcache_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dcache_if #(.LINE_BITS(256)) bus ();

   dcache_controller #(.LINES(16), .LINE_BITS(256)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [255:0] bmem [logic [31:0]];
   logic [31:0]  gold [logic [31:0]];
   bit           mv [16];
   bit           md [16];
   logic [22:0]  mt [16];

   typedef struct {
      logic [31:0]  rdata;
      int           stalls;
      int           n_wb;
      int           n_al;
      logic [31:0]  wb_addr;
      logic [255:0] wb_data;
      logic [31:0]  al_addr;
      logic [31:0]  first_addr;
      logic         first_we;
      bit           unstable;
      bit           timeout;
   } obs_t;

   typedef struct {
      bit           hit;
      bit           wb;
      logic [31:0]  wb_addr;
      logic [255:0] wb_line;
      logic [31:0]  al_addr;
      logic [31:0]  rdata;
      int           stalls;
   } exp_t;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      if (a == 32'h40) return 32'hDEAD_BEEF;
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [255:0] get_line(input logic [31:0] la);
      logic [255:0] l;
      if (bmem.exists(la)) return bmem[la];
      for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + 32'(w * 4));
      return l;
   endfunction

   function automatic logic [31:0] gold_rd(input logic [31:0] a);
      logic [255:0] l;
      if (gold.exists(a)) return gold[a];
      l = get_line({a[31:5], 5'b0});
      return l[a[4:2]*32 +: 32];
   endfunction

   function automatic logic [255:0] gold_line(input logic [31:0] la);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[w*32 +: 32] = gold_rd(la + 32'(w * 4));
      return l;
   endfunction

   task automatic predict(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input int lwb, input int lal, output exp_t e);
      int i;
      i         = int'(a[8:5]);
      e.hit     = mv[i] && (mt[i] == a[31:9]);
      e.wb      = !e.hit && mv[i] && md[i];
      e.wb_addr = {mt[i], a[8:5], 5'b0};
      e.wb_line = gold_line(e.wb_addr);
      e.al_addr = {a[31:5], 5'b0};
      e.rdata   = gold_rd({a[31:2], 2'b00});
      e.stalls  = e.hit ? 0 : (1 + lal + (e.wb ? lwb : 0));
      if (!e.hit) begin
         mv[i] = 1'b1;
         md[i] = 1'b0;
         mt[i] = a[31:9];
      end
      if (we) begin
         md[i] = 1'b1;
         gold[{a[31:2], 2'b00}] = wd;
      end
   endtask

   // Dirty lines vanish on reset, so their words revert to whatever memory holds.
   task automatic model_reset();
      logic [255:0] l;
      logic [31:0]  la;
      for (int i = 0; i < 16; i++) begin
         if (mv[i] && md[i]) begin
            la = {mt[i], 4'(i), 5'b0};
            l  = get_line(la);
            for (int w = 0; w < 8; w++) gold[la + 32'(w * 4)] = l[w*32 +: 32];
         end
         mv[i] = 1'b0;
         md[i] = 1'b0;
      end
   endtask

   // Drives one CPU access and plays the memory side with the given latencies.
   task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input int lwb, input int lal, output obs_t o);
      int           ph;
      logic [31:0]  pa;
      logic [255:0] pd;
      logic         pwe;
      o  = '{default: '0};
      ph = 0;
      pa = '0;
      pd = '0;
      pwe = 1'b0;
      bus.cpu_req_i  = 1'b1;
      bus.cpu_we_i   = we;
      bus.cpu_addr_i = a;
      bus.cpu_data_i = wd;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (!bus.cpu_stall_o) begin
            o.rdata = bus.cpu_data_o;
            @(posedge clk);
            #1;
            bus.cpu_req_i = 1'b0;
            bus.cpu_we_i  = 1'b0;
            return;
         end
         o.stalls++;
         if (bus.mem_req_o) begin
            if (ph == 0) begin
               pa  = bus.mem_addr_o;
               pd  = bus.mem_data_o;
               pwe = bus.mem_we_o;
               if (o.n_wb + o.n_al == 0) begin
                  o.first_addr = pa;
                  o.first_we   = pwe;
               end
            end else if (bus.mem_addr_o !== pa || bus.mem_data_o !== pd || bus.mem_we_o !== pwe) begin
               o.unstable = 1'b1;
            end
            ph++;
            if (ph == (bus.mem_we_o ? lwb : lal)) begin
               bus.mem_ack_i = 1'b1;
               if (bus.mem_we_o) begin
                  bmem[bus.mem_addr_o] = bus.mem_data_o;
                  o.n_wb++;
                  o.wb_addr = bus.mem_addr_o;
                  o.wb_data = bus.mem_data_o;
               end else begin
                  bus.mem_data_i = get_line(bus.mem_addr_o);
                  o.n_al++;
                  o.al_addr = bus.mem_addr_o;
               end
               ph = 0;
            end
         end
         @(posedge clk);
         #1;
         bus.mem_ack_i  = 1'b0;
         bus.mem_data_i = '0;
      end
      o.timeout     = 1'b1;
      bus.cpu_req_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = '0; bus.cpu_data_i = '0;
      bus.mem_ack_i = 1'b0; bus.mem_data_i = '0;
      for (int i = 0; i < 16; i++) begin mv[i] = 1'b0; md[i] = 1'b0; mt[i] = '0; end
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req_o); end
      n_checks++; if (bus.mem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b want 0", bus.mem_we_o); end
      n_checks++; if (bus.mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr_o); end
      n_checks++; if (bus.mem_data_o !== 256'h0) begin n_fail++; $display("FAIL reset_mem_data got %h want 0", bus.mem_data_o); end
      n_checks++; if (bus.cpu_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_cpu_data got %h want 0", bus.cpu_data_o); end
      n_checks++; if (bus.cpu_stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.cpu_stall_o); end
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.cpu_stall_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin
         n_fail++; $display("FAIL idle_no_req stall=%b mem_req=%b want 0/0", bus.cpu_stall_o, bus.mem_req_o); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_clean_miss();
      exp_t e; obs_t o;
      predict(1'b0, 32'h40, 32'h0, 1, 3, e);
      access(1'b0, 32'h40, 32'h0, 1, 3, o);
      n_checks++; if (o.timeout) begin n_fail++; $display("FAIL clean_miss_timeout got 1 want 0"); end
      n_checks++; if (o.first_we !== 1'b0 || o.first_addr !== 32'h40) begin
         n_fail++; $display("FAIL clean_miss_req we=%b addr=%h want 0/00000040", o.first_we, o.first_addr); end
      n_checks++; if (o.n_al != 1 || o.n_wb != 0) begin
         n_fail++; $display("FAIL clean_miss_traffic al=%0d wb=%0d want 1/0", o.n_al, o.n_wb); end
      n_checks++; if (o.stalls != e.stalls) begin n_fail++; $display("FAIL clean_miss_stalls got %0d want %0d", o.stalls, e.stalls); end
      n_checks++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL clean_miss_data got %h want %h", o.rdata, e.rdata); end
      n_checks++; if (o.unstable) begin n_fail++; $display("FAIL clean_miss_stable got unstable want stable"); end
   endtask

   task automatic test_store_hit();
      exp_t e; obs_t o;
      predict(1'b1, 32'h44, 32'h1234_5678, 1, 1, e);
      access(1'b1, 32'h44, 32'h1234_5678, 1, 1, o);
      n_checks++; if (o.stalls != e.stalls || o.n_al + o.n_wb != 0) begin
         n_fail++; $display("FAIL store_hit stalls=%0d traffic=%0d want %0d/0", o.stalls, o.n_al + o.n_wb, e.stalls); end
      predict(1'b0, 32'h44, 32'h0, 1, 1, e);
      access(1'b0, 32'h44, 32'h0, 1, 1, o);
      n_checks++; if (o.stalls != e.stalls || o.n_al + o.n_wb != 0) begin
         n_fail++; $display("FAIL load_hit stalls=%0d traffic=%0d want %0d/0", o.stalls, o.n_al + o.n_wb, e.stalls); end
      n_checks++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL load_hit_data got %h want %h", o.rdata, e.rdata); end
   endtask

   task automatic test_writeback();
      exp_t e; obs_t o;
      predict(1'b0, 32'h244, 32'h0, 2, 2, e);
      access(1'b0, 32'h244, 32'h0, 2, 2, o);
      n_checks++; if (o.n_wb != int'(e.wb) || o.wb_addr !== e.wb_addr) begin
         n_fail++; $display("FAIL wb_addr n=%0d addr=%h want %0d/%h", o.n_wb, o.wb_addr, e.wb, e.wb_addr); end
      n_checks++; if (o.wb_data[63:32] !== 32'h1234_5678) begin
         n_fail++; $display("FAIL wb_word1 got %h want 12345678", o.wb_data[63:32]); end
      n_checks++; if (o.wb_data !== e.wb_line) begin n_fail++; $display("FAIL wb_line got %h want %h", o.wb_data, e.wb_line); end
      n_checks++; if (o.al_addr !== e.al_addr) begin n_fail++; $display("FAIL wb_alloc_addr got %h want %h", o.al_addr, e.al_addr); end
      n_checks++; if (o.stalls != e.stalls || o.unstable) begin
         n_fail++; $display("FAIL wb_stalls got %0d (unstable=%0d) want %0d", o.stalls, o.unstable, e.stalls); end
      n_checks++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL wb_data_out got %h want %h", o.rdata, e.rdata); end
      predict(1'b0, 32'h40, 32'h0, 2, 1, e);
      access(1'b0, 32'h40, 32'h0, 2, 1, o);
      n_checks++; if (o.n_wb != 0 || o.stalls != e.stalls) begin
         n_fail++; $display("FAIL clean_after_fill wb=%0d stalls=%0d want 0/%0d", o.n_wb, o.stalls, e.stalls); end
      n_checks++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL refetch_data got %h want %h", o.rdata, e.rdata); end
   endtask

   task automatic test_reset_alloc();
      exp_t e; obs_t o;
      bit found;
      predict(1'b1, 32'hA0, 32'hCAFE_0001, 1, 2, e);
      access(1'b1, 32'hA0, 32'hCAFE_0001, 1, 2, o);
      found = 1'b0;
      bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h440;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.mem_req_o && !bus.mem_we_o) begin found = 1'b1; break; end
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL rst_alloc_reach got no ALLOCATE want ALLOCATE"); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (bus.mem_req_o !== 1'b0 || bus.mem_addr_o !== 32'h0) begin
         n_fail++; $display("FAIL rst_alloc_drop req=%b addr=%h want 0/0", bus.mem_req_o, bus.mem_addr_o); end
      n_checks++; if (bus.cpu_stall_o !== 1'b1) begin n_fail++; $display("FAIL rst_alloc_stall got %b want 1", bus.cpu_stall_o); end
      model_reset();
      @(negedge clk);
      bus.cpu_req_i = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      predict(1'b0, 32'h40, 32'h0, 1, 3, e);
      access(1'b0, 32'h40, 32'h0, 1, 3, o);
      n_checks++; if (o.n_al != 1 || o.stalls != e.stalls) begin
         n_fail++; $display("FAIL post_rst_miss al=%0d stalls=%0d want 1/%0d", o.n_al, o.stalls, e.stalls); end
      predict(1'b0, 32'hA0, 32'h0, 1, 2, e);
      access(1'b0, 32'hA0, 32'h0, 1, 2, o);
      n_checks++; if (o.n_wb != 0 || o.rdata !== e.rdata) begin
         n_fail++; $display("FAIL dirty_lost wb=%0d data=%h want 0/%h", o.n_wb, o.rdata, e.rdata); end
   endtask

   task automatic test_latency();
      exp_t e; obs_t o;
      predict(1'b0, 32'h800, 32'h0, 1, 1, e);
      access(1'b0, 32'h800, 32'h0, 1, 1, o);
      n_checks++; if (o.stalls != 2 || o.first_addr !== 32'h800) begin
         n_fail++; $display("FAIL lat1 stalls=%0d addr=%h want 2/00000800", o.stalls, o.first_addr); end
      n_checks++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL lat1_data got %h want %h", o.rdata, e.rdata); end
      predict(1'b0, 32'h1000, 32'h0, 1, 8, e);
      access(1'b0, 32'h1000, 32'h0, 1, 8, o);
      n_checks++; if (o.stalls != 9 || o.unstable) begin
         n_fail++; $display("FAIL lat8 stalls=%0d unstable=%0d want 9/0", o.stalls, o.unstable); end
      n_checks++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL lat8_data got %h want %h", o.rdata, e.rdata); end
   endtask

   task automatic test_spurious_ack();
      exp_t e; obs_t o;
      @(negedge clk);
      bus.mem_ack_i  = 1'b1;
      bus.mem_data_i = '1;
      @(posedge clk);
      #1;
      bus.mem_ack_i  = 1'b0;
      bus.mem_data_i = '0;
      @(negedge clk);
      n_checks++; if (bus.mem_req_o !== 1'b0 || bus.cpu_stall_o !== 1'b0) begin
         n_fail++; $display("FAIL spurious_ack req=%b stall=%b want 0/0", bus.mem_req_o, bus.cpu_stall_o); end
      @(posedge clk);
      #1;
      predict(1'b0, 32'h1004, 32'h0, 1, 1, e);
      access(1'b0, 32'h1004, 32'h0, 1, 1, o);
      n_checks++; if (o.stalls != e.stalls || o.rdata !== e.rdata) begin
         n_fail++; $display("FAIL spurious_hit stalls=%0d data=%h want %0d/%h", o.stalls, o.rdata, e.stalls, e.rdata); end
   endtask

   task automatic test_back_to_back();
      exp_t e; obs_t o;
      logic [31:0] addrs [6];
      bit          wes [6];
      logic [31:0] wd;
      int          lwb, lal;
      addrs = '{32'h300, 32'h500, 32'h304, 32'h508, 32'h300, 32'h500};
      wes   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      foreach (addrs[k]) begin
         wd  = $urandom;
         lwb = $urandom_range(1, 3);
         lal = $urandom_range(1, 3);
         predict(wes[k], addrs[k], wd, lwb, lal, e);
         access(wes[k], addrs[k], wd, lwb, lal, o);
         n_checks++; if (o.stalls != e.stalls || o.n_wb != int'(e.wb)) begin
            n_fail++; $display("FAIL b2b[%0d] stalls=%0d wb=%0d want %0d/%0d", k, o.stalls, o.n_wb, e.stalls, e.wb); end
         if (!wes[k]) begin
            n_checks++; if (o.rdata !== e.rdata) begin
               n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", k, o.rdata, e.rdata); end
         end
      end
   endtask

   task automatic test_random();
      exp_t e; obs_t o;
      logic [31:0] a, wd;
      bit          we;
      int          lwb, lal;
      for (int n = 0; n < 150; n++) begin
         a   = 32'(($urandom_range(0, 2) << 9) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2));
         we  = 1'($urandom_range(0, 1));
         wd  = $urandom;
         lwb = $urandom_range(1, 4);
         lal = $urandom_range(1, 4);
         predict(we, a, wd, lwb, lal, e);
         access(we, a, wd, lwb, lal, o);
         n_checks++; if (o.timeout || o.unstable) begin
            n_fail++; $display("FAIL rnd_hs[%0d] timeout=%0d unstable=%0d want 0/0", n, o.timeout, o.unstable); end
         n_checks++; if (o.stalls != e.stalls || o.n_wb != int'(e.wb)) begin
            n_fail++; $display("FAIL rnd_stall[%0d] a=%h stalls=%0d wb=%0d want %0d/%0d", n, a, o.stalls, o.n_wb, e.stalls, e.wb); end
         if (e.wb) begin
            n_checks++; if (o.wb_addr !== e.wb_addr || o.wb_data !== e.wb_line) begin
               n_fail++; $display("FAIL rnd_wb[%0d] addr=%h want %h data=%h want %h", n, o.wb_addr, e.wb_addr, o.wb_data, e.wb_line); end
         end
         if (!e.hit) begin
            n_checks++; if (o.al_addr !== e.al_addr) begin
               n_fail++; $display("FAIL rnd_al[%0d] got %h want %h", n, o.al_addr, e.al_addr); end
         end
         if (!we) begin
            n_checks++; if (o.rdata !== e.rdata) begin
               n_fail++; $display("FAIL rnd_data[%0d] a=%h got %h want %h", n, a, o.rdata, e.rdata); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_miss();
      test_store_hit();
      test_writeback();
      test_reset_alloc();
      test_latency();
      test_spurious_ack();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t want completion", $time);
      $fatal(1);
   end

endmodule
